// File: rtl/st_bus_pkg.sv
// Shared types and sizing helpers for the ST-bus frame scheduler.
// Frame geometry is derived from channel and bit counts, which must be powers of two.
package st_bus_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCK   = 2'd2
  } state_t;

  // good/bad frame counters and the CPU-visible slip counter
  localparam int CNT_W  = 3;
  localparam int SLIP_W = 8;

  // Half-bit positions per frame: each bit spans two c4 periods.
  function automatic int frame_len(input int channels, input int bits_per_ch);
    return 2 * channels * bits_per_ch;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CH_W  = idx_w(32);
  localparam int DEF_BIT_W = idx_w(8);
  localparam int DEF_HB_W  = idx_w(frame_len(32, 8));

endpackage

// File: rtl/st_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with a falling-edge tick.
// The tick is combinational from the last two flops and lands SYNC+1 cycles after the pin.
module st_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{RST_VAL}};
      last <= RST_VAL;
    end else begin
      sync[0] <= d;
      for (int i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
      last <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign fall  = last & ~sync[STAGES-1];

endmodule

// File: rtl/st_frame_sched.sv
// ST-bus TDM frame scheduler: recovers frame/bit timing from c4/f0, qualifies lock,
// and issues per-bit strobes with channel/bit indices plus a per-frame CPU interrupt.
module st_frame_sched
  import st_bus_pkg::*;
#(
  parameter int CHANNELS    = 32,
  parameter int BITS_PER_CH = 8,
  parameter int LOCK_FRAMES = 2,
  parameter int LOSS_FRAMES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk50,
  input  logic                         reset_n,
  input  logic                         c4,
  input  logic                         f0,
  input  logic [CHANNELS-1:0]          ch_mask,
  input  logic                         int_ack,
  output logic                         locked,
  output logic                         frame_start,
  output logic                         bit_strobe,
  output logic [idx_w(CHANNELS)-1:0]   ch_idx,
  output logic [idx_w(BITS_PER_CH)-1:0] bit_idx,
  output logic                         ch_active,
  output logic                         cpu_int,
  output logic [SLIP_W-1:0]            slip_cnt
);

  localparam int FL    = frame_len(CHANNELS, BITS_PER_CH);
  localparam int HB_W  = idx_w(FL);
  localparam int CH_W  = idx_w(CHANNELS);
  localparam int BIT_W = idx_w(BITS_PER_CH);

  localparam logic [HB_W-1:0]  HB_LAST = HB_W'(FL - 1);
  localparam logic [CNT_W-1:0] LOCK_N  = CNT_W'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0] LOSS_N  = CNT_W'(LOSS_FRAMES);

  function automatic logic [SLIP_W-1:0] sat_inc(input logic [SLIP_W-1:0] v);
    return (v == {SLIP_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // c4 idles low through reset so a high pin after release never fakes a tick;
  // f0 idles high (inactive).
  logic c4_fall, c4_level_unused;
  logic f0_level, f0_fall_unused;

  st_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_c4 (
    .clk   (clk50),
    .rst_n (reset_n),
    .d     (c4),
    .level (c4_level_unused),
    .fall  (c4_fall)
  );

  st_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_f0 (
    .clk   (clk50),
    .rst_n (reset_n),
    .d     (f0),
    .level (f0_level),
    .fall  (f0_fall_unused)
  );

  state_t            state, state_nx;
  logic [HB_W-1:0]   hb, hb_nx;
  logic [CNT_W-1:0]  good, good_nx, bad, bad_nx;
  logic [SLIP_W-1:0] slip_nx;
  logic              mark, at_exp, in_lock;
  logic [CNT_W-1:0]  good_inc, bad_inc;

  assign mark     = ~f0_level;
  assign at_exp   = (hb == HB_LAST);
  assign in_lock  = (state == LOCK);
  assign good_inc = good + 1'b1;
  assign bad_inc  = bad + 1'b1;

  // Control registers: FSM, half-bit position, good/bad qualifiers, slip count.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SEARCH;
      hb       <= '0;
      good     <= '0;
      bad      <= '0;
      slip_cnt <= '0;
    end else begin
      state    <= state_nx;
      hb       <= hb_nx;
      good     <= good_nx;
      bad      <= bad_nx;
      slip_cnt <= slip_nx;
    end
  end

  always_comb begin
    state_nx = state;
    hb_nx    = hb;
    good_nx  = good;
    bad_nx   = bad;
    slip_nx  = slip_cnt;
    if (c4_fall) begin
      // Any mark realigns; otherwise free-run with wrap at the frame end.
      hb_nx = (mark || at_exp) ? '0 : hb + 1'b1;
      case (state)
        SEARCH: begin
          if (mark) begin
            state_nx = CHECK;
            good_nx  = '0;
          end
        end
        CHECK: begin
          if (mark && at_exp) begin
            good_nx = good_inc;
            if (good_inc >= LOCK_N) begin
              state_nx = LOCK;
              bad_nx   = '0;
            end
          end else if (mark || at_exp) begin
            state_nx = SEARCH;
          end
        end
        LOCK: begin
          if (mark && at_exp) begin
            bad_nx = '0;
          end else if (mark || at_exp) begin
            bad_nx  = bad_inc;
            slip_nx = sat_inc(slip_cnt);
            if (bad_inc >= LOSS_N) state_nx = SEARCH;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  logic strobe_nx, fs_nx;
  assign strobe_nx = c4_fall & in_lock & hb_nx[0];
  assign fs_nx     = c4_fall & in_lock & (hb_nx == '0);

  // Registered strobes; indices follow the strobe and hold between strobes.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      bit_strobe  <= 1'b0;
      frame_start <= 1'b0;
      ch_idx      <= '0;
      bit_idx     <= '0;
      cpu_int     <= 1'b0;
    end else begin
      bit_strobe  <= strobe_nx;
      frame_start <= fs_nx;
      if (strobe_nx) begin
        ch_idx  <= hb_nx[HB_W-1:BIT_W+1];
        bit_idx <= hb_nx[BIT_W:1];
      end
      if (frame_start)  cpu_int <= 1'b1;
      else if (int_ack) cpu_int <= 1'b0;
    end
  end

  assign locked    = in_lock;
  assign ch_active = in_lock & ch_mask[ch_idx];

endmodule

// File: tb/tb_st_frame_sched.sv
// Directed bench for st_frame_sched: drives c4/f0 frames and checks strobes against a
// scoreboard of expected channel/bit positions pushed as each c4 period is driven.
module tb_st_frame_sched;

  logic        clk50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        c4 = 1'b0;
  logic        f0 = 1'b1;
  logic [31:0] ch_mask = '0;
  logic        int_ack = 1'b0;
  logic        locked, frame_start, bit_strobe, ch_active, cpu_int;
  logic [4:0]  ch_idx;
  logic [2:0]  bit_idx;
  logic [7:0]  slip_cnt;

  st_frame_sched dut (
    .clk50       (clk50),
    .reset_n     (reset_n),
    .c4          (c4),
    .f0          (f0),
    .ch_mask     (ch_mask),
    .int_ack     (int_ack),
    .locked      (locked),
    .frame_start (frame_start),
    .bit_strobe  (bit_strobe),
    .ch_idx      (ch_idx),
    .bit_idx     (bit_idx),
    .ch_active   (ch_active),
    .cpu_int     (cpu_int),
    .slip_cnt    (slip_cnt)
  );

  always #10 clk50 = ~clk50;

  int total = 0;
  int bad = 0;
  int sq[$];
  int fsq[$];
  int exp_hb = 0;
  int nstrobe = 0;
  bit ack_on_fs = 1'b0;
  bit ack_clr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clk50 cycle; outputs sampled 1 time unit after the edge.
  task automatic step();
    int e;
    @(posedge clk50);
    #1;
    if (ack_clr) begin
      int_ack = 1'b0;
      ack_clr = 1'b0;
    end
    if (bit_strobe) begin
      chk("strobe_expected", 32'(sq.size() != 0), 32'd1);
      if (sq.size() != 0) begin
        e = sq.pop_front();
        chk("strobe_idx", 32'({ch_idx, bit_idx}), 32'(e));
        chk("ch_active", 32'(ch_active), 32'(ch_mask[e >> 3]));
        nstrobe++;
      end
    end
    if (frame_start) begin
      chk("fs_expected", 32'(fsq.size() != 0), 32'd1);
      if (fsq.size() != 0) void'(fsq.pop_front());
      if (ack_on_fs) begin
        int_ack   = 1'b1;
        ack_on_fs = 1'b0;
        ack_clr   = 1'b1;
      end
    end
  endtask

  // One c4 period (4 high + 4 low); f0 low across the falling edge when mark is set.
  task automatic c4_period(input bit mark, input bit lock);
    int nh;
    c4 = 1'b1;
    f0 = ~mark;
    nh = (mark || exp_hb == 511) ? 0 : exp_hb + 1;
    if (lock && (nh % 2 == 1)) sq.push_back(nh >> 1);
    if (lock && nh == 0) fsq.push_back(1);
    exp_hb = nh;
    repeat (4) step();
    c4 = 1'b0;
    repeat (4) step();
  endtask

  task automatic run(input int n, input bit lock);
    repeat (n) c4_period(1'b0, lock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_bit_strobe"}, 32'(bit_strobe), 32'd0);
    chk({tag, "_ch_idx"}, 32'(ch_idx), 32'd0);
    chk({tag, "_bit_idx"}, 32'(bit_idx), 32'd0);
    chk({tag, "_ch_active"}, 32'(ch_active), 32'd0);
    chk({tag, "_cpu_int"}, 32'(cpu_int), 32'd0);
    chk({tag, "_slip_cnt"}, 32'(slip_cnt), 32'd0);
  endtask

  initial begin
    repeat (3) step();
    chk_all_zero("reset");
    reset_n = 1'b1;
    run(5, 1'b0);

    // Acquisition: three marks 512 c4 periods apart
    c4_period(1'b1, 1'b0); run(511, 1'b0);
    c4_period(1'b1, 1'b0); run(511, 1'b0);
    chk("locked_before_mark3", 32'(locked), 32'd0);
    c4_period(1'b1, 1'b0);
    chk("lock_rise", 32'(locked), 32'd1);

    // First locked frame with mask 0x5
    ch_mask = 32'h0000_0005;
    nstrobe = 0;
    run(511, 1'b1);
    chk("cpu_int_before_fs", 32'(cpu_int), 32'd0);
    c4_period(1'b1, 1'b1);
    chk("strobes_per_frame", 32'(nstrobe), 32'd256);
    chk("sq_empty_f4", 32'(sq.size()), 32'd0);
    chk("fs_seen_f4", 32'(fsq.size()), 32'd0);
    chk("int_set", 32'(cpu_int), 32'd1);

    // Interrupt: lone ack clears, ack coincident with frame_start keeps it set
    run(100, 1'b1);
    int_ack = 1'b1; step(); int_ack = 1'b0; step();
    chk("int_clear", 32'(cpu_int), 32'd0);
    run(411, 1'b1);
    ack_on_fs = 1'b1;
    c4_period(1'b1, 1'b1);
    chk("int_set_wins", 32'(cpu_int), 32'd1);
    chk("fs_seen_f5", 32'(fsq.size()), 32'd0);
    int_ack = 1'b1; step(); int_ack = 1'b0; step();
    chk("int_lone_ack", 32'(cpu_int), 32'd0);

    // Slip: mark 10 c4 periods early
    run(501, 1'b1);
    c4_period(1'b1, 1'b1);
    chk("slip_one", 32'(slip_cnt), 32'd1);
    chk("locked_after_slip", 32'(locked), 32'd1);
    run(511, 1'b1);
    c4_period(1'b1, 1'b1);
    chk("slip_hold", 32'(slip_cnt), 32'd1);
    chk("sq_empty_slip", 32'(sq.size()), 32'd0);

    // Loss: two frames without f0
    run(512, 1'b1);
    chk("slip_miss1", 32'(slip_cnt), 32'd2);
    chk("locked_miss1", 32'(locked), 32'd1);
    run(512, 1'b1);
    chk("slip_miss2", 32'(slip_cnt), 32'd3);
    chk("locked_lost", 32'(locked), 32'd0);
    ch_mask = 32'hFFFF_FFFF;
    step();
    chk("ch_active_lost", 32'(ch_active), 32'd0);
    ch_mask = 32'h0000_0005;
    chk("sq_empty_loss", 32'(sq.size()), 32'd0);
    chk("fs_seen_loss", 32'(fsq.size()), 32'd0);

    // Relock after f0 returns
    c4_period(1'b1, 1'b0); run(511, 1'b0);
    c4_period(1'b1, 1'b0); run(511, 1'b0);
    chk("relock_pre", 32'(locked), 32'd0);
    c4_period(1'b1, 1'b0);
    chk("relock", 32'(locked), 32'd1);

    // Asynchronous reset mid-frame while locked
    run(100, 1'b1);
    chk("cpu_int_before_reset", 32'(cpu_int), 32'd1);
    chk("slip_before_reset", 32'(slip_cnt), 32'd3);
    step();
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    sq.delete();
    fsq.delete();
    repeat (3) step();
    chk("held_reset_locked", 32'(locked), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
